// File: rtl/finalprojsoc_coordinate_capture.sv
// Avalon-MM coordinate capture port: fabric pushes coordinates into a small FIFO, the CPU pops them.
// Define COORD_CAPTURE_SYNC_EN to add two-flop synchronizers and rising-edge push detection on the fabric side.
module finalprojsoc_coordinate_capture #(
  parameter int DATA_WIDTH = 20,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  input  logic                  in_valid,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam logic [3:0] LP_DEPTH = 4'(DEPTH);
  localparam logic [2:0] LP_LAST  = 3'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [2:0]            r_wptr;
  logic [2:0]            r_rptr;
  logic [3:0]            r_count;
  logic                  r_ovf;
  logic [1:0]            r_mask;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push_q;
  logic                  w_push;
  logic                  w_ovf_set;
  logic                  w_ovf_clr;
  logic                  w_flush;
  logic                  w_mask_wr;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [DATA_WIDTH-1:0] w_head;
  logic [31:0]           w_status;
  logic                  w_unused;

  function automatic logic [2:0] f_next_ptr(input logic [2:0] ptr);
    f_next_ptr = (ptr == LP_LAST) ? 3'd0 : (ptr + 3'd1);
  endfunction

`ifdef COORD_CAPTURE_SYNC_EN
  logic [DATA_WIDTH-1:0] r_port_s1;
  logic [DATA_WIDTH-1:0] r_port_s2;
  logic                  r_valid_s1;
  logic                  r_valid_s2;
  logic                  r_valid_d;

  // Two-flop synchronizers plus one delay stage for edge detection on the strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_port_s1  <= '0;
      r_port_s2  <= '0;
      r_valid_s1 <= 1'b0;
      r_valid_s2 <= 1'b0;
      r_valid_d  <= 1'b0;
    end else begin
      r_port_s1  <= in_port;
      r_port_s2  <= r_port_s1;
      r_valid_s1 <= in_valid;
      r_valid_s2 <= r_valid_s1;
      r_valid_d  <= r_valid_s2;
    end
  end

  assign w_push_q    = r_valid_s2 & ~r_valid_d;
  assign w_push_data = r_port_s2;
`else
  assign w_push_q    = in_valid;
  assign w_push_data = in_port;
`endif

  assign w_rd      = chipselect & ~read_n;
  assign w_wr      = chipselect & ~write_n;
  assign w_empty   = (r_count == 4'd0);
  assign w_full    = (r_count == LP_DEPTH);
  assign w_flush   = w_wr & (address == 2'd3) & writedata[0];
  assign w_ovf_clr = w_wr & (address == 2'd1) & writedata[6];
  assign w_mask_wr = w_wr & (address == 2'd2);
  assign w_pop     = w_rd & (address == 2'd0) & ~w_empty & ~w_flush;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign w_push    = w_push_q & ~w_flush & (~w_full | w_pop);
  assign w_ovf_set = w_push_q & ~w_flush & w_full & ~w_pop;
  assign w_head    = r_mem[r_rptr];
  assign w_status  = {25'd0, r_ovf, w_full, w_empty, r_count};
  assign w_unused  = ^{writedata[31:7], writedata[5:2]};

  // FIFO storage, pointers, count, sticky overflow and interrupt mask
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= 3'd0;
      r_rptr  <= 3'd0;
      r_count <= 4'd0;
      r_ovf   <= 1'b0;
      r_mask  <= 2'd0;
    end else begin
      if (w_flush) begin
        r_wptr  <= 3'd0;
        r_rptr  <= 3'd0;
        r_count <= 4'd0;
      end else begin
        if (w_push) begin
          r_mem[r_wptr] <= w_push_data;
          r_wptr        <= f_next_ptr(r_wptr);
        end
        if (w_pop) begin
          r_rptr <= f_next_ptr(r_rptr);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 4'd1;
          2'b01:   r_count <= r_count - 4'd1;
          default: r_count <= r_count;
        endcase
      end
      // A fresh overflow in the same cycle as a clear is kept so it is never lost
      if (w_flush) begin
        r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_mask_wr) begin
        r_mask <= writedata[1:0];
      end
    end
  end

  // Zero-wait-state read mux, driven only while a read is in progress
  always_comb begin
    readdata = 32'd0;
    if (w_rd) begin
      case (address)
        2'd0:    readdata = w_empty ? 32'd0 : 32'(w_head);
        2'd1:    readdata = w_status;
        2'd2:    readdata = {30'd0, r_mask};
        default: readdata = 32'd0;
      endcase
    end else begin
      readdata = 32'd0;
    end
  end

  assign irq = (r_mask[0] & ~w_empty) | (r_mask[1] & r_ovf);

endmodule

// File: tb/tb_finalprojsoc_coordinate_capture.sv
// Scoreboard bench for finalprojsoc_coordinate_capture: queue-based reference model, directed plan then random traffic.
module tb_finalprojsoc_coordinate_capture;

  localparam int DW    = 20;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          read_n = 1'b1;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [DW-1:0] in_port = '0;
  logic          in_valid = 1'b0;
  logic [31:0]   readdata;
  logic          irq;

  finalprojsoc_coordinate_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .in_valid(in_valid), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        irq;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  // Reference model: a plain queue of pending coordinates plus flag state
  int unsigned m_q[$];
  bit          m_ovf;
  bit [1:0]    m_mask;
  bit          h_v1, h_v2, h_v3;
  int unsigned h_p1, h_p2;

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_mask = 2'd0;
    h_v1 = 1'b0; h_v2 = 1'b0; h_v3 = 1'b0;
    h_p1 = 0;    h_p2 = 0;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] port, input bit rd, input bit wr,
                       input bit [1:0] addr, input bit [31:0] wd);
    exp_t        e;
    int unsigned sz;
    bit          push;
    int unsigned pdata;
    bit          popped;
    bit          set_ovf;
    @(posedge clk);
    #1;
    in_valid   = v;
    in_port    = port;
    chipselect = rd | wr;
    read_n     = ~rd;
    write_n    = ~wr;
    address    = addr;
    writedata  = wd;
    sz = m_q.size();
    e.rdata = 32'd0;
    if (rd) begin
      case (addr)
        2'd0:    e.rdata = (sz != 0) ? 32'(m_q[0]) : 32'd0;
        2'd1:    e.rdata = 32'(sz) | ((sz == 0) ? 32'h10 : 32'h0) |
                           ((sz == DEPTH) ? 32'h20 : 32'h0) | (m_ovf ? 32'h40 : 32'h0);
        2'd2:    e.rdata = {30'd0, m_mask};
        default: e.rdata = 32'd0;
      endcase
    end
    e.irq = (m_mask[0] && sz != 0) || (m_mask[1] && m_ovf);
    sbq.push_back(e);
`ifdef COORD_CAPTURE_SYNC_EN
    push  = h_v2 && !h_v3;
    pdata = h_p2;
    h_v3 = h_v2; h_v2 = h_v1; h_v1 = v;
    h_p2 = h_p1; h_p1 = 32'(port);
`else
    push  = v;
    pdata = 32'(port);
`endif
    popped  = 1'b0;
    set_ovf = 1'b0;
    if (wr && addr == 2'd3 && wd[0]) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (rd && addr == 2'd0 && sz != 0) begin
        void'(m_q.pop_front());
        popped = 1'b1;
      end
      if (push) begin
        if (sz < DEPTH || popped) m_q.push_back(pdata);
        else set_ovf = 1'b1;
      end
      if (wr && addr == 2'd1 && wd[6]) m_ovf = 1'b0;
      if (set_ovf) m_ovf = 1'b1;
    end
    if (wr && addr == 2'd2) m_mask = wd[1:0];
  endtask

  task automatic idle();           drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 32'd0); endtask
  task automatic push(input logic [DW-1:0] d); drive(1'b1, d, 1'b0, 1'b0, 2'd0, 32'd0); endtask
  task automatic rd(input bit [1:0] a);        drive(1'b0, '0, 1'b1, 1'b0, a, 32'd0); endtask
  task automatic wr(input bit [1:0] a, input bit [31:0] d); drive(1'b0, '0, 1'b0, 1'b1, a, d); endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    reset_n = 1'b0;
    model_reset();
    #2;
    reset_n = 1'b1;
  endtask

  // Directed check of the plan's fixed values, sampled mid-cycle
  task automatic dchk(input string name, input logic [31:0] exp_rd, input logic exp_irq);
    @(negedge clk);
    n_cmp++;
    if (readdata !== exp_rd || irq !== exp_irq) begin
      n_fail++;
      $display("FAIL %s: readdata=0x%08h irq=%b, expected readdata=0x%08h irq=%b",
               name, readdata, irq, exp_rd, exp_irq);
    end
  endtask

  // Monitor: every driven cycle produced one expectation; compare it against the DUT
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_cmp++;
      if (readdata !== e.rdata) begin
        n_fail++;
        $display("FAIL sb_readdata @%0t: got 0x%08h expected 0x%08h", $time, readdata, e.rdata);
      end
      n_cmp++;
      if (irq !== e.irq) begin
        n_fail++;
        $display("FAIL sb_irq @%0t: got %b expected %b", $time, irq, e.irq);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    int unsigned phase;
    int unsigned pv;
    model_reset();
    #12;
    reset_n = 1'b1;

    rd(2'd1); dchk("reset_status", 32'h10, 1'b0);
    rd(2'd0); dchk("reset_data", 32'h0, 1'b0);
    idle();   dchk("reset_idle", 32'h0, 1'b0);

`ifndef COORD_CAPTURE_SYNC_EN
    push(20'h12345);
    push(20'hABCDE);
    rd(2'd1); dchk("two_count2", 32'h2, 1'b0);
    rd(2'd0); dchk("two_first", 32'h12345, 1'b0);
    rd(2'd1); dchk("two_count1", 32'h1, 1'b0);
    rd(2'd0); dchk("two_second", 32'hABCDE, 1'b0);
    rd(2'd1); dchk("two_count0", 32'h10, 1'b0);
    rd(2'd0); dchk("empty_read", 32'h0, 1'b0);

    for (int i = 1; i <= 9; i++) push(DW'(i));
    rd(2'd1); dchk("ovf_status", 32'h68, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      rd(2'd0); dchk("ovf_drain", 32'(i), 1'b0);
    end
    rd(2'd1); dchk("ovf_sticky", 32'h50, 1'b0);
    wr(2'd1, 32'h40);
    rd(2'd1); dchk("ovf_cleared", 32'h10, 1'b0);

    for (int i = 0; i < 8; i++) push(DW'(32'h100 + 32'(i)));
    drive(1'b1, 20'h77777, 1'b1, 1'b0, 2'd0, 32'd0); dchk("full_pushpop", 32'h100, 1'b0);
    rd(2'd1); dchk("full_pushpop_status", 32'h28, 1'b0);
    for (int i = 1; i < 8; i++) begin
      rd(2'd0); dchk("full_drain", 32'h100 + 32'(i), 1'b0);
    end
    rd(2'd0); dchk("full_last", 32'h77777, 1'b0);

    wr(2'd2, 32'h1);
    push(20'h05555); dchk("irq_not_yet", 32'h0, 1'b0);
    idle();          dchk("irq_rise", 32'h0, 1'b1);
    rd(2'd2);        dchk("mask_read", 32'h1, 1'b1);
    wr(2'd3, 32'h1); dchk("irq_flush_cycle", 32'h0, 1'b1);
    rd(2'd1);        dchk("irq_after_flush", 32'h10, 1'b0);

    drive(1'b1, 20'h33333, 1'b0, 1'b1, 2'd3, 32'h1);
    rd(2'd1); dchk("flush_beats_push", 32'h10, 1'b0);

    push(20'h00001);
    push(20'h00002);
    do_reset();
    rd(2'd1); dchk("midop_reset_status", 32'h10, 1'b0);
    rd(2'd2); dchk("midop_reset_mask", 32'h0, 1'b0);
`else
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 20'h00042, 1'b1, 1'b0, 2'd1, 32'd0);
      dchk("sync_hold_count", (i < 3) ? 32'h10 : 32'h1, 1'b0);
    end
    idle(); idle(); idle();
    rd(2'd1); dchk("sync_single_push", 32'h1, 1'b0);
    rd(2'd0); dchk("sync_data", 32'h42, 1'b0);
`endif

    for (int i = 0; i < 4000; i++) begin
      if (i == 2500) do_reset();
      phase = (i / 200) % 3;
      r  = $urandom_range(0, 99);
      pv = (phase == 0) ? 80 : ((phase == 1) ? 15 : 45);
      if (r < 45) begin
        drive($urandom_range(0, 99) < pv, DW'($urandom), 1'b0, 1'b0, 2'd0, 32'd0);
      end else if (r < 75) begin
        drive($urandom_range(0, 99) < pv, DW'($urandom), 1'b1, 1'b0, 2'd0, 32'd0);
      end else if (r < 88) begin
        drive($urandom_range(0, 99) < pv, DW'($urandom), 1'b1, 1'b0, 2'($urandom_range(1, 3)), 32'd0);
      end else if (r < 93) begin
        drive($urandom_range(0, 99) < pv, DW'($urandom), 1'b0, 1'b1, 2'd1, $urandom);
      end else if (r < 98) begin
        drive($urandom_range(0, 99) < pv, DW'($urandom), 1'b0, 1'b1, 2'd2, $urandom);
      end else begin
        drive($urandom_range(0, 99) < pv, DW'($urandom), 1'b0, 1'b1, 2'd3, $urandom);
      end
    end

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/finalprojsoc_coordinate_capture.md
# finalprojsoc_coordinate_capture

Avalon-MM slave input port that carries 20-bit coordinates from fabric logic back to the Nios II. Fabric logic strobes coordinates in; the block queues them in an 8-entry FIFO. The CPU pops entries by reading the data register and polls the status register or takes an interrupt. It sits in `finalprojsoc` beside the output PIOs and provides the fabric-to-CPU direction of the same register-mapped port scheme.

## Interface
- `DATA_WIDTH`, 20: coordinate width; readdata is zero-extended to 32.
- `DEPTH`, 8: FIFO entries; must be a power of two, at most 8.
- `clk` in 1: system clock, single domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `read_n` in 1: active-low read strobe.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `in_port` in 20: coordinate from fabric.
- `in_valid` in 1: push strobe from fabric.
- `readdata` out 32: read data, combinational, zero wait states.
- `irq` out 1: level interrupt, active-high.

## Operation
- Access decode:
  - rd = `chipselect & ~read_n`
  - wr = `chipselect & ~write_n`
- addr 0, DATA (read only):
  - Returns `{12'b0, head}` when the FIFO is non-empty, otherwise 0.
  - Each rd cycle pops one entry when the FIFO is non-empty.
  - A read when empty does nothing and does not flag an error.
- addr 1, STATUS:
  - Bits [3:0] = count (0..8), [4] = empty, [5] = full, [6] = overflow (sticky), [31:7] = 0.
  - A write with `writedata[6]=1` clears overflow.
- addr 2, IRQMASK (R/W, bits [1:0]):
  - Bit 0 enables the not-empty interrupt; bit 1 enables the overflow interrupt.
  - Other bits read 0.
- addr 3, CONTROL:
  - A write with `writedata[0]=1` flushes the FIFO (count to 0, pointers to 0) and clears overflow.
  - Reads return 0.
- `irq = (mask[0] & ~empty) | (mask[1] & overflow)`. It is decoded combinationally from registered state.
- Push:
  - A push occurs in every cycle where the push qualifier is high (see Configuration).
  - Push when not full: `in_port` is written at the write pointer, and count increments.
  - Push when full with no pop in the same cycle: the data is dropped and overflow is set. The FIFO contents are unchanged.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - When full, this pushes without overflow.
  - When empty, only the push happens; the read returns 0.
- Flush in the same cycle as a push or pop: flush wins and the push data is discarded.
- Pointers are 3-bit and wrap from 7 to 0. Count is 4-bit, and the full condition is count == DEPTH.

## Timing
- Reset values:
  - count 0, pointers 0, overflow 0, mask 0.
  - `irq` 0; `readdata` 0 for every address.
  - Synchronizer flops 0.
- Reset mid-operation discards all queued entries immediately (asynchronous).
- Push latency: an `in_valid` sampled at edge N makes count and head visible after edge N.
  - The not-empty interrupt asserts in the cycle after edge N.
- Pop: the read at edge N returns the current head combinationally. The next entry is presented after edge N.
- Writes take effect at the edge that samples them.
- The mask write and the irq change are one cycle apart.

## Configuration
- `COORD_CAPTURE_SYNC_EN` defined:
  - `in_port` and `in_valid` pass through two-flop synchronizers.
  - The push qualifier is the rising edge of the synchronized `in_valid`, so one push is made per assertion regardless of its length.
  - The pushed data is the synchronized `in_port`. The source must hold `in_port` stable while `in_valid` is high.
  - Push latency grows to 3 edges from the `in_valid` rise.
- Undefined:
  - `in_valid` is a synchronous qualifier; every high cycle pushes `in_port` directly.
  - No synchronizer flops are built.

## Test plan
- Reset, then read addr 1 and addr 0 -> STATUS = 0x10 (empty), DATA = 0, `irq` = 0.
- Push 0x12345, 0xABCDE, then read addr 0 twice -> 0x12345 then 0xABCDE. STATUS count goes 2 -> 1 -> 0.
- Push 9 values (1..9) with no reads -> STATUS = 0x68 (count 8, full, overflow). Reading 8 times returns 1..8. A write of 0x40 to addr 1 clears overflow.
- FIFO full, push 0x77777 in the same cycle as a read of addr 0 -> read returns the oldest entry, count stays 8, overflow stays 0, and 0x77777 becomes the last entry.
- Write IRQMASK = 1, push one value -> `irq` rises the next cycle. Write addr 3 = 1 -> `irq` falls and STATUS = 0x10.
- With `COORD_CAPTURE_SYNC_EN`, hold `in_valid` high 5 cycles with `in_port` = 0x00042 -> exactly one entry (0x00042), count 1 visible 3 edges after the rise.
